// File: rtl/skinny_mask_pkg.sv
// Shared constants for the 3-share SKINNY-64 inverse S-box, split as InvS = G(F(x)).
// F and G are quadratic 4-bit bijections held as ANF coefficient tables.
package skinny_mask_pkg;

    localparam int NSHARES = 3;
    localparam int LATENCY = 4;

    // Entry x holds InvS(x); x = 0 sits in the rightmost nibble.
    localparam logic [15:0][3:0] INV_SBOX = {
        4'hF, 4'hD, 4'hB, 4'h0, 4'h7, 4'h5, 4'h2, 4'h9,
        4'hE, 4'h1, 4'hA, 4'hC, 4'h8, 4'h6, 4'h4, 4'h3
    };

    // quad bit order: 0:x0x1 1:x0x2 2:x0x3 3:x1x2 4:x1x3 5:x2x3
    typedef struct packed {
        logic       cnst;
        logic [3:0] lin;
        logic [5:0] quad;
    } anf_bit_t;

    typedef anf_bit_t [3:0] anf_fn_t;

    localparam anf_fn_t F_ANF = '{
        '{1'b0, 4'b0111, 6'b100100},
        '{1'b1, 4'b1101, 6'b100000},
        '{1'b0, 4'b1000, 6'b000000},
        '{1'b0, 4'b0100, 6'b000000}
    };

    localparam anf_fn_t G_ANF = '{
        '{1'b1, 4'b1101, 6'b100000},
        '{1'b0, 4'b1000, 6'b000000},
        '{1'b0, 4'b0100, 6'b000000},
        '{1'b0, 4'b0111, 6'b100100}
    };

    // Component function for share pair (a, b): cross products a_p*b_q for every
    // quadratic monomial; linear terms only on the diagonal pair; constant once.
    function automatic logic [3:0] cf_eval(
        input anf_fn_t    f,
        input logic [3:0] xa,
        input logic [3:0] xb,
        input logic       diag,
        input logic       with_const
    );
        logic [3:0] y;
        logic [5:0] prod;
        prod = {xa[2] & xb[3], xa[1] & xb[3], xa[1] & xb[2],
                xa[0] & xb[3], xa[0] & xb[2], xa[0] & xb[1]};
        y = '0;
        for (int b = 0; b < 4; b++) begin
            y[b] = (f[b].cnst & with_const)
                 ^ ((^(f[b].lin & xa)) & diag)
                 ^ (^(f[b].quad & prod));
        end
        return y;
    endfunction

endpackage

// File: rtl/skinny_q_stage_3sh.sv
// Quadratic 4-bit map on three Boolean shares: nine share-pair CF registers, then compress + remask.
// Latency 2 cycles; accepts a nibble every cycle, no backpressure.
module skinny_q_stage_3sh
    import skinny_mask_pkg::*;
#(
    parameter anf_fn_t ANF = F_ANF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    input  logic [7:0] r,
    output logic [3:0] out1,
    output logic [3:0] out2,
    output logic [3:0] out3
);

    logic [NSHARES-1:0][3:0]              sh;
    logic [NSHARES-1:0][NSHARES-1:0][3:0] cf_q;
    logic [3:0] grp1, grp2, grp3;
    logic [3:0] ra, rb;

    assign sh = {in3, in2, in1};

    // CF(i,j) sees only shares i and j of each variable; registering them stops glitches
    // from recombining all three shares before compression.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cf_q <= '0;
        end else begin
            for (int i = 0; i < NSHARES; i++) begin
                for (int j = 0; j < NSHARES; j++) begin
                    cf_q[i][j] <= cf_eval(ANF, sh[i], sh[j], i == j, (i == 0) && (j == 0));
                end
            end
        end
    end

    // Each group spans only two share indices, so no XOR cone holds all three shares.
    assign grp1 = cf_q[0][0] ^ cf_q[0][1] ^ cf_q[1][0];
    assign grp2 = cf_q[1][1] ^ cf_q[1][2] ^ cf_q[2][1];
    assign grp3 = cf_q[2][2] ^ cf_q[2][0] ^ cf_q[0][2];

    assign ra = {r[6], r[4], r[2], r[0]};
    assign rb = {r[7], r[5], r[3], r[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1 <= '0;
            out2 <= '0;
            out3 <= '0;
        end else begin
            out1 <= grp1 ^ ra;
            out2 <= grp2 ^ rb;
            out3 <= grp3 ^ ra ^ rb;
        end
    end

endmodule

// File: rtl/skinny_inv_sbox4_3sh.sv
// Second-order masked SKINNY-64 inverse S-box on three shares, computed as G(F(x)).
// Latency 4 cycles (2 per quadratic stage); throughput one nibble per cycle, no backpressure.
module skinny_inv_sbox4_3sh #(
    parameter int LATENCY = skinny_mask_pkg::LATENCY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [3:0]  in1,
    input  logic [3:0]  in2,
    input  logic [3:0]  in3,
    input  logic [15:0] r,
    output logic        out_valid,
    output logic [3:0]  out1,
    output logic [3:0]  out2,
    output logic [3:0]  out3
);

    logic [3:0]         f1, f2, f3;
    logic [LATENCY-1:0] vld_sr;

    skinny_q_stage_3sh #(
        .ANF (skinny_mask_pkg::F_ANF)
    ) u_stage_f (
        .clk   (clk),
        .rst_n (rst_n),
        .in1   (in1),
        .in2   (in2),
        .in3   (in3),
        .r     (r[7:0]),
        .out1  (f1),
        .out2  (f2),
        .out3  (f3)
    );

    skinny_q_stage_3sh #(
        .ANF (skinny_mask_pkg::G_ANF)
    ) u_stage_g (
        .clk   (clk),
        .rst_n (rst_n),
        .in1   (f1),
        .in2   (f2),
        .in3   (f3),
        .r     (r[15:8]),
        .out1  (out1),
        .out2  (out2),
        .out3  (out3)
    );

    // Valid rides alongside the data; share registers run every cycle regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= {vld_sr[LATENCY-2:0], in_valid};
        end
    end

    assign out_valid = vld_sr[LATENCY-1];

endmodule

// File: tb/tb_skinny_inv_sbox4_3sh.sv
// Scoreboard bench for skinny_inv_sbox4_3sh: directed nibbles with random share splits and masks.
module tb_skinny_inv_sbox4_3sh;

    localparam logic [3:0] INV_TAB [16] = '{
        4'h3, 4'h4, 4'h6, 4'h8, 4'hC, 4'hA, 4'h1, 4'hE,
        4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hB, 4'hD, 4'hF
    };

    typedef struct {
        logic [3:0] y_exp;
        int         issue;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in1, in2, in3;
    logic [15:0] r;
    logic        out_valid;
    logic [3:0]  out1, out2, out3;

    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_mis = 0;
    exp_t        q[$];
    logic        track = 1'b0;
    logic [15:0] seen  = '0;

    skinny_inv_sbox4_3sh #(.LATENCY(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .r         (r),
        .out_valid (out_valid),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard whenever the DUT presents a result, checks value and latency.
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] y;
        if (rst_n === 1'b1) begin
            y = out1 ^ out2 ^ out3;
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_mis++;
                    $display("FAIL unexpected_valid: out_valid=1 y=%h at cycle %0d, required out_valid=0", y, cyc);
                end else begin
                    e = q.pop_front();
                    if (y !== e.y_exp || cyc != e.issue + 4) begin
                        n_mis++;
                        $display("FAIL result: y=%h at cycle %0d, required y=%h at cycle %0d",
                                 y, cyc, e.y_exp, e.issue + 4);
                    end
                    if (track) seen[out1] = 1'b1;
                end
            end else if (q.size() != 0 && cyc >= q[0].issue + 4) begin
                e = q.pop_front();
                n_cmp++;
                n_mis++;
                $display("FAIL missing_valid: out_valid=%b at cycle %0d, required 1 with y=%h",
                         out_valid, cyc, e.y_exp);
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y_exp);
        logic [3:0] s1, s2;
        exp_t       e;
        @(posedge clk);
        #1;
        s1       = 4'($urandom);
        s2       = 4'($urandom);
        in_valid = v;
        in1      = s1;
        in2      = s2;
        in3      = x ^ s1 ^ s2;
        r        = 16'($urandom);
        if (v) begin
            e.y_exp = y_exp;
            e.issue = cyc;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 12) begin
            drive(1'b0, 4'($urandom), 4'h0);
            n++;
        end
        @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_reset(input string tag);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL %s_valid: out_valid=%b, required 0", tag, out_valid);
        end
        n_cmp++;
        if ({out1, out2, out3} !== 12'h000) begin
            n_mis++;
            $display("FAIL %s_shares: shares=%h, required 000", tag, {out1, out2, out3});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget, %0d results outstanding", q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in1      = '0;
        in2      = '0;
        in3      = '0;
        r        = '0;

        // Reset held with random traffic on the inputs.
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom);
            in1      = 4'($urandom);
            in2      = 4'($urandom);
            in3      = 4'($urandom);
            r        = 16'($urandom);
            @(negedge clk);
            check_reset("reset");
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // All sixteen inputs back to back.
        for (int x = 0; x < 16; x++) drive(1'b1, 4'(x), INV_TAB[x]);
        drain();

        // Fixed x = A under many share splits and masks.
        track = 1'b1;
        for (int k = 0; k < 100; k++) drive(1'b1, 4'hA, 4'h5);
        drain();
        track = 1'b0;
        n_cmp++;
        if ($countones(seen) < 2) begin
            n_mis++;
            $display("FAIL share_variety: %0d distinct out1 values, required at least 2", $countones(seen));
        end

        // Bubble pattern 1,0,1,1,0.
        drive(1'b1, 4'h3, 4'h8);
        drive(1'b0, 4'h7, 4'h0);
        drive(1'b1, 4'h9, 4'h2);
        drive(1'b1, 4'hB, 4'h7);
        drive(1'b0, 4'hE, 4'h0);
        drain();

        // Reset while three nibbles are in flight: none may emerge.
        drive(1'b1, 4'h1, 4'h4);
        drive(1'b1, 4'h2, 4'h6);
        drive(1'b1, 4'h3, 4'h8);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        check_reset("midflight");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 4'h0, 4'h0);
        drive(1'b0, 4'h0, 4'h0);
        drive(1'b1, 4'hF, 4'hF);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
